// File: rtl/pawan_alu_seq.sv
// pawan_alu_seq
// Handshaked, parameterised successor to the CPU's combinational ALU. It sits
// between operand fetch and writeback. Single-cycle operations return a
// registered result one cycle after acceptance. MUL/MULH run as an iterative
// shift-add multiplier that retires one multiplier bit per cycle.
//
// Configuration macro: PAWAN_ALU_MUL_EN
//   defined   : opcodes 10 (MUL) and 11 (MULH) use the IDLE/MUL machine.
//   undefined : the multiplier is not built, and opcodes 10/11 are illegal.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand bundle valid
//   in_ready   block can accept a bundle this cycle
//   op_code    operation select (4 bits)
//   rs1_in     operand A (WIDTH bits)
//   rs2_in     operand B (WIDTH bits); shift amount is rs2_in[SHW-1:0]
//   cin        carry-in for ADD
//   bin        borrow-in for SUB
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     operation result (WIDTH bits)
//   flags      {ovf, carry, neg, zero}
//   illegal    op_code of the current result was unsupported
module pawan_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] rs1_in,
  input  logic [WIDTH-1:0] rs2_in,
  input  logic             cin,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;

  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_illegal;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_aluRes;
  logic             w_aluCarry;
  logic             w_aluOvf;
  logic             w_aluIllegal;
  logic             w_accept;
  logic             w_loadAlu;
  logic             w_loadMul;
  logic [WIDTH-1:0] w_mulRes;

  assign w_shamt  = rs2_in[SHW-1:0];
  assign w_accept = in_valid && in_ready;

  // The extra top bit of the add is its carry-out. For the subtract, that
  // bit is the borrow-out, because the true difference lies in [-2^W, 2^W).
  assign w_sum  = {1'b0, rs1_in} + {1'b0, rs2_in} + {{WIDTH{1'b0}}, cin};
  assign w_diff = {1'b0, rs1_in} - {1'b0, rs2_in} - {{WIDTH{1'b0}}, bin};

  always_comb begin
    w_aluRes     = '0;
    w_aluCarry   = 1'b0;
    w_aluOvf     = 1'b0;
    w_aluIllegal = 1'b0;
    case (op_code)
      OP_ADD: begin
        w_aluRes   = w_sum[WIDTH-1:0];
        w_aluCarry = w_sum[WIDTH];
        w_aluOvf   = (rs1_in[WIDTH-1] == rs2_in[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != rs1_in[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluRes   = w_diff[WIDTH-1:0];
        w_aluCarry = w_diff[WIDTH];
        w_aluOvf   = (rs1_in[WIDTH-1] != rs2_in[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != rs1_in[WIDTH-1]);
      end
      OP_AND: w_aluRes = rs1_in & rs2_in;
      OP_OR:  w_aluRes = rs1_in | rs2_in;
      OP_XOR: w_aluRes = rs1_in ^ rs2_in;
      OP_NOT: w_aluRes = ~rs1_in;
      OP_SHL: w_aluRes = rs1_in << w_shamt;
      OP_SHR: w_aluRes = rs1_in >> w_shamt;
      OP_SRA: w_aluRes = $unsigned($signed(rs1_in) >>> w_shamt);
      OP_SLT: w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(rs1_in) < $signed(rs2_in))};
      // MUL/MULH are never loaded from this path when the multiplier is built.
      default: w_aluIllegal = 1'b1;
    endcase
  end

`ifdef PAWAN_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} mulState_t;

  mulState_t          r_state;
  mulState_t          w_stateNext;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_count;
  logic               r_mulHigh;
  logic               w_isMulOp;
  logic               w_mulDone;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_accNext;

  assign w_isMulOp = (op_code == OP_MUL) || (op_code == OP_MULH);
  assign w_partial = r_mplier[r_count] ? ({{WIDTH{1'b0}}, r_mcand} << r_count) : '0;
  assign w_accNext = r_acc + w_partial;
  assign w_mulDone = (r_state == S_MUL) && (r_count == SHW'(WIDTH-1));
  assign w_mulRes  = r_mulHigh ? w_accNext[2*WIDTH-1:WIDTH] : w_accNext[WIDTH-1:0];
  assign w_loadMul = w_mulDone;
  assign w_loadAlu = w_accept && !w_isMulOp;
  assign in_ready  = (r_state == S_IDLE) && (!r_outValid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_isMulOp) w_stateNext = S_MUL;
      S_MUL:  if (w_mulDone)             w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // The multiplier datapath: operands are latched on accept, then one partial
  // product is added per cycle. The final add feeds result directly through
  // w_accNext, so the accumulator never needs an extra cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_mulHigh <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_isMulOp) begin
        r_mcand   <= rs1_in;
        r_mplier  <= rs2_in;
        r_acc     <= '0;
        r_count   <= '0;
        r_mulHigh <= (op_code == OP_MULH);
      end
    end else begin
      r_acc   <= w_accNext;
      r_count <= r_count + 1'b1;
    end
  end
`else
  assign w_mulRes  = '0;
  assign w_loadMul = 1'b0;
  assign w_loadAlu = w_accept;
  assign in_ready  = !r_outValid || out_ready;
`endif

  // The output register. A new result always wins over the consumer's clear,
  // which allows one single-cycle op per clock when out_ready stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_illegal  <= 1'b0;
    end else if (w_loadMul) begin
      r_outValid <= 1'b1;
      r_result   <= w_mulRes;
      r_flags    <= {2'b00, w_mulRes[WIDTH-1], (w_mulRes == '0)};
      r_illegal  <= 1'b0;
    end else if (w_loadAlu) begin
      r_outValid <= 1'b1;
      r_result   <= w_aluRes;
      r_flags    <= {w_aluOvf, w_aluCarry, w_aluRes[WIDTH-1], (w_aluRes == '0)};
      r_illegal  <= w_aluIllegal;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_pawan_alu_seq.sv
// tb_pawan_alu_seq
// Bench for pawan_alu_seq at WIDTH=16. It uses a vector table of known and
// model-derived cases, plus hand sequences for result hold, latency, the
// iterative multiply and reset in the middle of a multiply. Expected results
// are queued when a bundle is accepted. They are checked when the DUT hands a
// result over.
module tb_pawan_alu_seq;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] rs1_in;
  logic [WIDTH-1:0] rs2_in;
  logic             cin;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        bi;
    exp_t        e;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[64];
  int   nVec  = 0;
  int   total = 0;
  int   bad   = 0;

  pawan_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .rs1_in    (rs1_in),
    .rs2_in    (rs2_in),
    .cin       (cin),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written in wide integer arithmetic, kept independent of
  // the bit-slice formulas in the design.
  function automatic exp_t modelAlu(input logic [3:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic ci, input logic bi);
    exp_t        e;
    longint      ua;
    longint      ub;
    longint      sa;
    longint      sb;
    longint      t;
    longint      st;
    logic [15:0] r;
    logic        c;
    logic        v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; e.ill = 1'b0;
    case (op)
      4'd0: begin
        t = ua + ub + longint'(ci); r = t[15:0]; c = t[16];
        st = sa + sb + longint'(ci); v = (st > 32767) || (st < -32768);
      end
      4'd1: begin
        t = ua - ub - longint'(bi); r = t[15:0]; c = (t < 0);
        st = sa - sb - longint'(bi); v = (st > 32767) || (st < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << b[3:0];
      4'd7: r = a >> b[3:0];
      4'd8: begin t = sa >>> b[3:0]; r = t[15:0]; end
      4'd9: r = (sa < sb) ? 16'd1 : 16'd0;
      default: begin r = '0; e.ill = 1'b1; end
    endcase
    e.res = r;
    e.fl  = {v, c, r[15], (r == 16'd0)};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic bi,
                        input logic [15:0] res, input logic [3:0] fl, input logic ill);
    vecs[nVec].op    = op;
    vecs[nVec].a     = a;
    vecs[nVec].b     = b;
    vecs[nVec].ci    = ci;
    vecs[nVec].bi    = bi;
    vecs[nVec].e.res = res;
    vecs[nVec].e.fl  = fl;
    vecs[nVec].e.ill = ill;
    nVec++;
  endtask

  // This task drives one bundle and holds in_valid until it is accepted. It
  // leaves in_valid high so that consecutive calls run back to back.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic ci, input logic bi,
                               input exp_t e, input bit push, output int stalls);
    op_code  = op;
    rs1_in   = a;
    rs2_in   = b;
    cin      = ci;
    bin      = bi;
    in_valid = 1'b1;
    stalls   = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready got %b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (push) sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // This is the scoreboard side. Each handed-over result is checked against
  // the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got %h want none", result);
      end else begin
        e = sbQ.pop_front();
        checkOutput("result",  32'(result),  32'(e.res));
        checkOutput("flags",   32'(flags),   32'(e.fl));
        checkOutput("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t        e;
    int          st;
    int          stallSum;
    int          cyc;
    bit          seen;
    logic [3:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rbi;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_code = '0; rs1_in = '0; rs2_in = '0; cin = 1'b0; bin = 1'b0;

    // Known-answer vectors, then random vectors scored by the model.
    addVec(4'd2, 16'h0006, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0);
    addVec(4'd0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 4'b0100, 1'b0);
    addVec(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b1010, 1'b0);
    addVec(4'd1, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFD, 4'b0110, 1'b0);
    addVec(4'd1, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 4'b0000, 1'b0);
    addVec(4'd1, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 4'b1000, 1'b0);
    addVec(4'd8, 16'h8000, 16'h0013, 1'b0, 1'b0, 16'hF000, 4'b0010, 1'b0);
    addVec(4'd3, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 16'h0FF0, 4'b0000, 1'b0);
    addVec(4'd4, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0);
    addVec(4'd5, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hFF00, 4'b0010, 1'b0);
    addVec(4'd6, 16'h0001, 16'h0004, 1'b0, 1'b0, 16'h0010, 4'b0000, 1'b0);
    addVec(4'd7, 16'h8000, 16'h000F, 1'b0, 1'b0, 16'h0001, 4'b0000, 1'b0);
    addVec(4'd9, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0001, 4'b0000, 1'b0);
    addVec(4'd9, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0);
    addVec(4'd13, 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b1);
`ifndef PAWAN_ALU_MUL_EN
    addVec(4'd10, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b1);
`endif
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 13));
      if (rop >= 4'd10) rop = rop + 4'd2;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      rbi = 1'($urandom);
      e   = modelAlu(rop, ra, rb, rc, rbi);
      addVec(rop, ra, rb, rc, rbi, e.res, e.fl, e.ill);
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result",    32'(result),    32'd0);
    checkOutput("reset_flags",     32'(flags),     32'd0);
    checkOutput("reset_illegal",   32'(illegal),   32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table, issued back to back with out_ready held high
    stallSum = 0;
    for (int i = 0; i < nVec; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].bi,
                    vecs[i].e, 1'b1, st);
      stallSum += st;
    end
    in_valid = 1'b0;
    checkOutput("throughput_stalls", 32'(stallSum), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Result hold under back-pressure
    out_ready = 1'b0;
    e.res = 16'h12FF; e.fl = 4'b0000; e.ill = 1'b0;
    applyStimulus(4'd3, 16'h1234, 16'h00FF, 1'b0, 1'b0, e, 1'b1, st);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("hold_latency_valid", 32'(out_valid), 32'd1);
    checkOutput("hold_in_ready",      32'(in_ready),  32'd0);
    repeat (3) @(negedge clk);
    checkOutput("hold_result",    32'(result),    32'h12FF);
    checkOutput("hold_flags",     32'(flags),     32'd0);
    checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
    checkOutput("hold_in_ready2", 32'(in_ready),  32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Illegal opcode returns after a single cycle
    e.res = 16'h0000; e.fl = 4'b0001; e.ill = 1'b1;
`ifdef PAWAN_ALU_MUL_EN
    applyStimulus(4'd13, 16'h0F0F, 16'h0003, 1'b0, 1'b0, e, 1'b1, st);
`else
    applyStimulus(4'd10, 16'h0F0F, 16'h0003, 1'b0, 1'b0, e, 1'b1, st);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("illegal_latency", 32'(out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

`ifdef PAWAN_ALU_MUL_EN
    // MULH with in_ready low for the whole multiply
    e.res = 16'hFFFE; e.fl = 4'b0010; e.ill = 1'b0;
    applyStimulus(4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, e, 1'b1, st);
    in_valid = 1'b0;
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) cyc++;
    end
    checkOutput("mulh_busy_cycles", 32'(cyc), 32'd16);
    repeat (2) @(posedge clk);
    #1;

    // MUL low half
    e.res = 16'h0001; e.fl = 4'b0000; e.ill = 1'b0;
    applyStimulus(4'd10, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, e, 1'b1, st);
    in_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    applyStimulus(4'd10, 16'h0003, 16'h0005, 1'b0, 1'b0, e, 1'b0, st);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("mulrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mulrst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("mulrst_no_result", 32'(seen),     32'd0);
    checkOutput("mulrst_ready",     32'(in_ready), 32'd1);
`endif

    for (int k = 0; k < 100; k++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
